// File: rtl/ijtag_tdr_access_seq.sv
// Host-side IJTAG sequencer: runs one capture-shift-update access on a TDR segment per request
// and returns the bits collected from ijtag_so.
module ijtag_tdr_access_seq #(
   parameter int unsigned MAX_LEN = 32,
   parameter int unsigned LEN_W   = 6
) (
   input  logic               ijtag_tck,
   input  logic               ijtag_reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [LEN_W-1:0]   req_len,
   input  logic [MAX_LEN-1:0] req_wdata,
   input  logic               req_no_update,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_rdata,
   output logic               rsp_err,
   output logic               busy,
   output logic               ijtag_sel,
   output logic               ijtag_ce,
   output logic               ijtag_se,
   output logic               ijtag_ue,
   output logic               ijtag_si,
   input  logic               ijtag_so
);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StCapture = 3'd1;
   localparam logic [2:0] StShift   = 3'd2;
   localparam logic [2:0] StUpdate  = 3'd3;
   localparam logic [2:0] StResp    = 3'd4;

   localparam logic [LEN_W-1:0]   MaxLen = LEN_W'(MAX_LEN);
   localparam logic [MAX_LEN-1:0] BitOne = MAX_LEN'(1);

   logic [2:0]         state_q, state_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [MAX_LEN-1:0] wdata_q, wdata_d;
   logic [MAX_LEN-1:0] mask_q, mask_d;
   logic [MAX_LEN-1:0] rdata_q, rdata_d;
   logic               err_q, err_d;
   logic               no_upd_q, no_upd_d;
   logic               si_d;
   logic               req_ready_q, rsp_valid_q, busy_q;
   logic               sel_q, ce_q, se_q, ue_q, si_q;
   logic               len_bad;

   assign len_bad = (req_len == '0) || (req_len > MaxLen);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wdata_d  = wdata_q;
      mask_d   = mask_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      no_upd_d = no_upd_q;
      si_d     = 1'b0;
      case (state_q)
         StIdle: begin
            if (req_valid && req_ready_q) begin
               wdata_d  = req_wdata;
               no_upd_d = req_no_update;
               cnt_d    = req_len - LEN_W'(1);
               mask_d   = BitOne;
               rdata_d  = '0;
               err_d    = len_bad;
               state_d  = len_bad ? StResp : StCapture;
            end
         end
         StCapture: begin
            si_d    = wdata_q[0];
            wdata_d = wdata_q >> 1;
            state_d = StShift;
         end
         StShift: begin
            // so is low-phase retimed, so this edge sees the TDR bit before the current shift
            if (ijtag_so) rdata_d = rdata_q | mask_q;
            mask_d = mask_q << 1;
            if (cnt_q == '0) begin
               state_d = no_upd_q ? StResp : StUpdate;
            end else begin
               cnt_d   = cnt_q - LEN_W'(1);
               si_d    = wdata_q[0];
               wdata_d = wdata_q >> 1;
            end
         end
         StUpdate: state_d = StResp;
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ijtag_tck) begin
      if (ijtag_reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         no_upd_q    <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         sel_q       <= 1'b0;
         ce_q        <= 1'b0;
         se_q        <= 1'b0;
         ue_q        <= 1'b0;
         si_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         no_upd_q    <= no_upd_d;
         // Outputs are decoded from the next state so they line up with state_q
         req_ready_q <= (state_d == StIdle);
         rsp_valid_q <= (state_d == StResp);
         busy_q      <= (state_d != StIdle);
         sel_q       <= (state_d == StCapture) || (state_d == StShift) || (state_d == StUpdate);
         ce_q        <= (state_d == StCapture);
         se_q        <= (state_d == StShift);
         ue_q        <= (state_d == StUpdate);
         si_q        <= si_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign busy      = busy_q;
   assign ijtag_sel = sel_q;
   assign ijtag_ce  = ce_q;
   assign ijtag_se  = se_q;
   assign ijtag_ue  = ue_q;
   assign ijtag_si  = si_q;

endmodule

// File: tb/tb_ijtag_tdr_access_seq.sv
// Directed bench for ijtag_tdr_access_seq with a behavioural TDR chain (capture/shift/update,
// so retimed on the low phase).
module tb_ijtag_tdr_access_seq;

   logic        ijtag_tck = 1'b0;
   logic        ijtag_reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  req_len = '0;
   logic [31:0] req_wdata = '0;
   logic        req_no_update = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic        ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
   logic        ijtag_so;

   ijtag_tdr_access_seq #(.MAX_LEN(32), .LEN_W(6)) dut (
      .ijtag_tck     (ijtag_tck),
      .ijtag_reset   (ijtag_reset),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_len       (req_len),
      .req_wdata     (req_wdata),
      .req_no_update (req_no_update),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdata     (rsp_rdata),
      .rsp_err       (rsp_err),
      .busy          (busy),
      .ijtag_sel     (ijtag_sel),
      .ijtag_ce      (ijtag_ce),
      .ijtag_se      (ijtag_se),
      .ijtag_ue      (ijtag_ue),
      .ijtag_si      (ijtag_si),
      .ijtag_so      (ijtag_so)
   );

   always #5 ijtag_tck = ~ijtag_tck;

   // TDR chain model: cell 0 drives so, si enters cell tdr_len-1
   int          tdr_len = 1;
   logic [31:0] tdr_cap = '0;
   logic [31:0] tdr_sr = '0;
   logic [31:0] tdr_dout = 32'h1;
   logic        so_q = 1'b0;
   logic [63:0] len_mask;

   assign len_mask = (64'd1 << tdr_len) - 64'd1;
   assign ijtag_so = so_q;

   always @(posedge ijtag_tck) begin
      if (ijtag_sel && ijtag_ce) tdr_sr <= tdr_cap;
      else if (ijtag_sel && ijtag_se) tdr_sr <= (tdr_sr >> 1) | ({31'b0, ijtag_si} << (tdr_len - 1));
      if (ijtag_sel && ijtag_ue) tdr_dout <= tdr_sr & len_mask[31:0];
   end

   always @(negedge ijtag_tck) so_q <= tdr_sr[0];

   // Activity monitor; counters only grow, the bench works with differences
   int se_cnt = 0, ce_cnt = 0, ue_cnt = 0, sel_cnt = 0, rv_cnt = 0, excl_err = 0;
   always @(negedge ijtag_tck) begin
      if (ijtag_se) se_cnt++;
      if (ijtag_ce) ce_cnt++;
      if (ijtag_ue) ue_cnt++;
      if (ijtag_sel) sel_cnt++;
      if (rsp_valid) rv_cnt++;
      if ((int'(ijtag_ce) + int'(ijtag_se) + int'(ijtag_ue)) > 1 ||
          (!ijtag_sel && (ijtag_ce || ijtag_se || ijtag_ue))) excl_err++;
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   int          d_se, d_ce, d_ue, d_sel;
   int          lat;
   logic [31:0] rd;
   logic        er;

   task automatic do_req(input logic [5:0] len, input logic [31:0] wd, input logic nu,
                         input int hold);
      int s_se, s_ce, s_ue, s_sel;
      @(posedge ijtag_tck); #1;
      s_se = se_cnt; s_ce = ce_cnt; s_ue = ue_cnt; s_sel = sel_cnt;
      @(negedge ijtag_tck);
      check_eq("req_ready_idle", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1; req_len = len; req_wdata = wd; req_no_update = nu;
      @(posedge ijtag_tck); #1;
      // Scramble request inputs; the sequencer must have latched them
      req_valid = 1'b0; req_len = 6'd0; req_wdata = ~wd; req_no_update = ~nu;
      lat = 1;
      forever begin
         @(negedge ijtag_tck);
         if (rsp_valid) break;
         @(posedge ijtag_tck);
         lat++;
         if (lat > 400) begin
            check_eq("rsp_timeout", 32'd1, 32'd0);
            break;
         end
      end
      rd = rsp_rdata;
      er = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge ijtag_tck);
         check_eq("hold_valid", {31'b0, rsp_valid}, 32'd1);
         check_eq("hold_rdata", rsp_rdata, rd);
         check_eq("hold_busy", {31'b0, busy}, 32'd1);
         check_eq("hold_req_ready", {31'b0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge ijtag_tck); #1;
      rsp_ready = 1'b0;
      @(negedge ijtag_tck);
      check_eq("post_idle", {29'b0, req_ready, busy, rsp_valid}, 32'b100);
      d_se = se_cnt - s_se; d_ce = ce_cnt - s_ce; d_ue = ue_cnt - s_ue; d_sel = sel_cnt - s_sel;
   endtask

   initial begin
      int s_rv;
      repeat (3) @(posedge ijtag_tck);
      #1 ijtag_reset = 1'b0;
      @(negedge ijtag_tck);
      check_eq("rst_ready_busy_valid", {29'b0, req_ready, busy, rsp_valid}, 32'b100);
      check_eq("rst_rdata", rsp_rdata, 32'd0);
      check_eq("rst_err", {31'b0, rsp_err}, 32'd0);
      check_eq("rst_ctrl", {27'b0, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}, 32'd0);

      // 1-bit TDR, reset-state out 1, captures 0, written with 1
      tdr_len = 1; tdr_cap = 32'h0;
      do_req(6'd1, 32'h1, 1'b0, 0);
      check_eq("t1_lat", lat, 32'd4);
      check_eq("t1_rdata", rd, 32'h0);
      check_eq("t1_err", {31'b0, er}, 32'd0);
      check_eq("t1_ce_se_ue", {d_ce[7:0], d_se[7:0], d_ue[7:0]}, 32'h010101);
      check_eq("t1_sel_cycles", d_sel, 32'd3);
      check_eq("t1_dout", tdr_dout, 32'h1);

      // Read-only access: no update, dout unchanged
      tdr_cap = 32'h1;
      do_req(6'd1, 32'h0, 1'b1, 0);
      check_eq("t2_lat", lat, 32'd3);
      check_eq("t2_rdata", rd, 32'h1);
      check_eq("t2_ue", d_ue, 32'd0);
      check_eq("t2_dout", tdr_dout, 32'h1);

      // Eight-cell chain
      tdr_len = 8; tdr_cap = 32'hA5;
      do_req(6'd8, 32'h3C, 1'b0, 0);
      check_eq("t3_lat", lat, 32'd11);
      check_eq("t3_rdata", rd, 32'h000000A5);
      check_eq("t3_se", d_se, 32'd8);
      check_eq("t3_dout", tdr_dout, 32'h3C);

      // Illegal lengths
      do_req(6'd0, 32'hFFFF_FFFF, 1'b0, 0);
      check_eq("t4a_err", {31'b0, er}, 32'd1);
      check_eq("t4a_rdata", rd, 32'h0);
      check_eq("t4a_sel", d_sel, 32'd0);
      do_req(6'd33, 32'hFFFF_FFFF, 1'b0, 0);
      check_eq("t4b_err", {31'b0, er}, 32'd1);
      check_eq("t4b_rdata", rd, 32'h0);
      check_eq("t4b_activity", d_sel + d_ce + d_se + d_ue, 32'd0);
      check_eq("t4_dout", tdr_dout, 32'h3C);

      // Full-length access with a stalled response
      tdr_len = 32; tdr_cap = 32'hDEADBEEF;
      do_req(6'd32, 32'h12345678, 1'b0, 5);
      check_eq("t5_lat", lat, 32'd35);
      check_eq("t5_rdata", rd, 32'hDEADBEEF);
      check_eq("t5_err", {31'b0, er}, 32'd0);
      check_eq("t5_se", d_se, 32'd32);
      check_eq("t5_dout", tdr_dout, 32'h12345678);

      // Reset during shift cycle 3 of a len=8 access
      tdr_len = 8; tdr_cap = 32'h77;
      @(posedge ijtag_tck); #1;
      s_rv = rv_cnt;
      @(negedge ijtag_tck);
      req_valid = 1'b1; req_len = 6'd8; req_wdata = 32'hFF; req_no_update = 1'b0;
      @(posedge ijtag_tck); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge ijtag_tck);
      @(negedge ijtag_tck);
      check_eq("t6_in_shift", {31'b0, ijtag_se}, 32'd1);
      ijtag_reset = 1'b1;
      @(posedge ijtag_tck); #1;
      ijtag_reset = 1'b0;
      @(negedge ijtag_tck);
      check_eq("t6_ctrl", {27'b0, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}, 32'd0);
      check_eq("t6_idle", {29'b0, req_ready, busy, rsp_valid}, 32'b100);
      repeat (20) @(negedge ijtag_tck);
      check_eq("t6_no_rsp", rv_cnt - s_rv, 32'd0);
      tdr_cap = 32'h5A;
      do_req(6'd8, 32'hC3, 1'b0, 0);
      check_eq("t6_lat", lat, 32'd11);
      check_eq("t6_rdata", rd, 32'h5A);
      check_eq("t6_dout", tdr_dout, 32'hC3);

      check_eq("excl_sel", excl_err, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ijtag_tdr_access_seq.md
Name: ijtag_tdr_access_seq

Overview:
- Host-side sequencer that drives the IJTAG control signals (sel/ce/se/ue/si) of one scan TDR segment and collects ijtag_so.
- Runs one full capture-shift-update access per host request.
- Sits between a register-mapped test controller and a TDR such as the 1-bit SRI TDRs, all on ijtag_tck.
- Returns the captured bits to the host and optionally suppresses the update.

Parameters:
- MAX_LEN, 32, maximum TDR length in bits; legal range 1..256.
- LEN_W, 6, width of req_len; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- ijtag_tck  in  1  only clock; all state is updated on posedge.
- ijtag_reset  in  1  synchronous, active-high reset.
- req_valid  in  1  access request.
- req_ready  out  1  high only in IDLE.
- req_len  in  LEN_W  number of shift cycles, equal to the TDR length.
- req_wdata  in  MAX_LEN  data to shift in; bit 0 is shifted first.
- req_no_update  in  1  1 means skip the UPDATE phase (read-only access).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_rdata  out  MAX_LEN  captured bits; bit k is the k-th bit out of ijtag_so; bits >= len are 0.
- rsp_err  out  1  1 means illegal length; no TDR activity occurred.
- busy  out  1  high whenever the FSM is not in IDLE.
- ijtag_sel  out  1  TDR select.
- ijtag_ce  out  1  capture enable.
- ijtag_se  out  1  shift enable.
- ijtag_ue  out  1  update enable.
- ijtag_si  out  1  scan data to the TDR.
- ijtag_so  in  1  scan data from the TDR (retimed on the low phase of ijtag_tck).

Behaviour:
- All outputs are registered.
- Reset values: req_ready=1 (in IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, and sel/ce/se/ue/si all 0.
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, RESP.
- IDLE:
  - A request is accepted when req_valid & req_ready. The FSM latches len, wdata and no_update.
  - If len==0 or len>MAX_LEN: go directly to RESP with rsp_err=1 and rsp_rdata=0. sel/ce/se/ue stay 0.
  - Otherwise go to CAPTURE.
- CAPTURE: exactly 1 cycle with sel=1, ce=1, se=0, ue=0. Then go to SHIFT.
- SHIFT: exactly len cycles with sel=1, se=1.
  - ijtag_si = wdata[k] in shift cycle k (k = 0..len-1).
  - At the posedge ending shift cycle k, sample ijtag_so into rdata[k].
  - Because the TDR's so is low-phase retimed, the value sampled at that posedge is TDR bit 0 before shift k. So rdata[0] is the captured LSB.
  - A down-counter is loaded with len-1. Leave SHIFT when the counter reaches 0.
- UPDATE: 1 cycle with sel=1, ue=1, se=0. This state is skipped when no_update=1.
- sel drops to 0 on the cycle after the last SHIFT or UPDATE cycle.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On the cycle with rsp_ready, return to IDLE. req_ready is high again on the following cycle, so there is no back-to-back acceptance in the same cycle.
- Latency from acceptance to the first rsp_valid cycle: 1 + 1 + len + (no_update ? 0 : 1) cycles. Example: len=1 with update gives rsp_valid 4 cycles after acceptance.
- ce, se and ue are mutually exclusive in every cycle. ce, se and ue are never high while sel=0.
- Reset mid-operation (any state) returns to IDLE on the next posedge with reset values. No response is issued for the aborted request. The TDR's own reset restores its outputs.
- Inputs are ignored outside IDLE; req_wdata changes after acceptance have no effect.
- req_len == MAX_LEN is legal; the counter must not overflow.

Test Plan:
- MAX_LEN=32, req_len=1, wdata=1, no_update=0, TDR reset-state out=1:
  - ce for 1 cycle, se for 1 cycle with si=1, then ue for 1 cycle.
  - rsp_rdata=0 (TDR captures 1'b0), rsp_err=0.
  - TDR data_out becomes 1 after ue.
- req_len=1, wdata=0, no_update=1:
  - No ue pulse, so TDR data_out is unchanged.
  - rsp_valid 3 cycles after acceptance.
- Chain of eight 1-bit TDRs modelled as an 8-bit shift with capture value 0xA5, req_len=8, wdata=0x3C:
  - rsp_rdata=0x000000A5.
  - After update, the TDRs hold 0x3C.
  - Total se cycles = 8.
- req_len=0, then req_len=33:
  - Each gives rsp_err=1 and rsp_rdata=0.
  - sel/ce/se/ue stay 0 throughout.
- req_len=32 with rsp_ready held low 5 cycles:
  - rsp_valid and rsp_rdata stay stable for those 5 cycles.
  - busy=1 until the handshake; req_ready=0 during RESP.
- Assert ijtag_reset in shift cycle 3 of a len=8 access:
  - Next cycle: all control outputs 0, state IDLE.
  - No rsp_valid is issued.
  - A new request completes normally afterwards.
